enemy_clk_monitor: RTL and testbench
====================================

ENEMY_CLK_MONITOR -- requirements
Module: enemy_clk_monitor

Interface
REQ-001 Parameter W, default 27'd999999, expected enemy-clock period in clock_in cycles.
REQ-002 Parameter TOL, default 27'd16, allowed period deviation (+/-) in cycles.
REQ-003 Parameter LOCK_N, default 4, consecutive in-tolerance periods required for lock.
REQ-004 clock_in  input  1  system clock; all logic on rising edge.
REQ-005 reset_n  input  1  reset; synchronous and active-low.
REQ-006 y_in  input  1  divided enemy square wave, asynchronous to clock_in.
REQ-007 period_out  output  27  last measured period, cycles between consecutive rises.
REQ-008 high_out  output  27  synchronized-high cycles within the last measured period.
REQ-009 valid  output  1  one-cycle pulse when period_out/high_out update.
REQ-010 locked  output  1  enemy clock stable at W +/- TOL.
REQ-011 stall  output  1  no rise seen for more than 2*W cycles.

Function
REQ-012 y_in SHALL pass a two-flop synchronizer; rise = synchronized high while previous synchronized sample low.
REQ-013 valid SHALL pulse exactly 3 clock_in cycles after the first rising clock_in edge sampling y_in high, provided state is not IDLE.
REQ-014 Period counter SHALL increment every cycle, reload to 1 on rise, saturate at 27'h7FFFFFF without wrap.
REQ-015 High counter SHALL increment each cycle synchronized y_in is high, reload on rise, saturate likewise.
REQ-016 On rise, period_out SHALL take the period count (P for a P-cycle wave) and high_out the high count, same cycle as valid.
REQ-017 States: IDLE, MEASURE, LOCKED, STALL.
REQ-018 IDLE: first rise -> MEASURE; counters start; no valid, outputs unchanged.
REQ-019 MEASURE: each rise with period in [W-TOL, W+TOL] increments streak; out-of-range clears streak to 0.
REQ-020 MEASURE -> LOCKED on the rise making streak equal LOCK_N; locked asserts same cycle as that valid.
REQ-021 LOCKED: any out-of-range period -> MEASURE, streak 0, locked deasserts same cycle as valid.
REQ-022 MEASURE or LOCKED: period counter exceeding 2*W -> STALL; stall=1, locked=0 next cycle.
REQ-023 STALL: next rise -> MEASURE, stall=0, streak 0; that rise produces no valid (measurement discarded).
REQ-024 Bounds inclusive; W-TOL computed unsigned, clamped to 0 on underflow.
REQ-025 Rise coinciding with 2*W overflow cycle: rise wins, no STALL.

Reset
REQ-026 reset_n low at a clock_in rise SHALL force IDLE, streak 0, counters 0, synchronizer 0, period_out 0, high_out 0, valid 0, locked 0, stall 0.
REQ-027 Reset mid-measurement SHALL discard the partial period; first rise after release only re-enters MEASURE.

Configuration
REQ-028 Macro ENEMY_CLK_DUTY_CHECK_EN defined: a period counts in-tolerance only if high_out also within [W/2-TOL, W/2+TOL].
REQ-029 Macro undefined: duty ignored; high_out still reported; lock depends on period only.

Verification
REQ-030 W=1000,TOL=16,LOCK_N=4; y_in period 1000 high 500 -> valid each rise, period_out=1000, high_out=500, locked=1 at 5th rise.
REQ-031 Locked, one period 1017 -> locked=0 on that valid, 4 further periods 1016 -> locked=1 again.
REQ-032 Locked, y_in held low -> stall=1, locked=0 after 2001 cycles beyond last rise; next rise clears stall, no valid.
REQ-033 reset_n low 1 cycle mid-period while locked -> all outputs 0 next cycle; relock needs 5 rises.
REQ-034 DUTY_CHECK_EN defined, period 1000 high 700 -> never locks; undefined -> locks at 5th rise.

Source files
------------

// File: rtl/enemy_clk_monitor.sv
// Enemy clock monitor: measures period/high time of an async square wave.
// Optional duty-cycle qualification for lock: define ENEMY_CLK_DUTY_CHECK_EN.
module enemy_clk_monitor #(
  parameter logic [26:0] W      = 27'd999999,
  parameter logic [26:0] TOL    = 27'd16,
  parameter int unsigned LOCK_N = 4
) (
  input  logic        clock_in,
  input  logic        reset_n,
  input  logic        y_in,
  output logic [26:0] period_out,
  output logic [26:0] high_out,
  output logic        valid,
  output logic        locked,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOCK,
    STALL
  } state_t;

  localparam logic [26:0] CMAX  = '1;
  localparam logic [27:0] LIM   = {W, 1'b0};
  localparam logic [26:0] P_LO  = (W > TOL) ? W - TOL : '0;
  localparam logic [27:0] P_HI  = {1'b0, W} + {1'b0, TOL};
`ifdef ENEMY_CLK_DUTY_CHECK_EN
  localparam logic [26:0] HALF  = W >> 1;
  localparam logic [26:0] D_LO  = (HALF > TOL) ? HALF - TOL : '0;
  localparam logic [27:0] D_HI  = {1'b0, HALF} + {1'b0, TOL};
`endif

  state_t      state, state_n;
  logic [15:0] streak, streak_n, streak_inc;
  logic [26:0] pcnt, hcnt;
  logic        s1, s2, s3, rise;
  logic        valid_n, in_rng, over;

  assign locked     = (state == LOCK);
  assign stall      = (state == STALL);
  assign streak_inc = streak + 16'd1;
  assign over       = {1'b0, pcnt} > LIM;

  always_comb begin
    in_rng = (pcnt >= P_LO) && ({1'b0, pcnt} <= P_HI);
`ifdef ENEMY_CLK_DUTY_CHECK_EN
    in_rng = in_rng && (hcnt >= D_LO) && ({1'b0, hcnt} <= D_HI);
`endif
  end

  always_comb begin
    state_n  = state;
    streak_n = streak;
    valid_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n  = MEASURE;
          streak_n = '0;
        end
      end
      MEASURE: begin
        if (rise) begin
          valid_n = 1'b1;
          if (in_rng) begin
            streak_n = streak_inc;
            if (streak_inc >= 16'(LOCK_N))
              state_n = LOCK;
          end else begin
            streak_n = '0;
          end
        end else if (over) begin
          state_n  = STALL;
          streak_n = '0;
        end
      end
      LOCK: begin
        if (rise) begin
          valid_n = 1'b1;
          if (!in_rng) begin
            state_n  = MEASURE;
            streak_n = '0;
          end
        end else if (over) begin
          state_n  = STALL;
          streak_n = '0;
        end
      end
      STALL: begin
        // measurement spanning the stall is meaningless, drop it
        if (rise) begin
          state_n  = MEASURE;
          streak_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      rise       <= 1'b0;
      state      <= IDLE;
      streak     <= '0;
      pcnt       <= '0;
      hcnt       <= '0;
      period_out <= '0;
      high_out   <= '0;
      valid      <= 1'b0;
    end else begin
      s1     <= y_in;
      s2     <= s1;
      s3     <= s2;
      rise   <= s2 & ~s3;
      state  <= state_n;
      streak <= streak_n;
      valid  <= valid_n;
      if (valid_n) begin
        period_out <= pcnt;
        high_out   <= hcnt;
      end
      // s3 is the level aligned with the registered rise
      if (rise) begin
        pcnt <= 27'd1;
        hcnt <= 27'd1;
      end else if (state != IDLE) begin
        if (pcnt != CMAX)
          pcnt <= pcnt + 27'd1;
        if (s3 && hcnt != CMAX)
          hcnt <= hcnt + 27'd1;
      end
    end
  end

endmodule

// File: tb/tb_enemy_clk_monitor.sv
// Directed bench for enemy_clk_monitor at W=1000, TOL=16, LOCK_N=4.
// Valid pulses are logged at negedge and checked against hand values.
module tb_enemy_clk_monitor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        y_in = 1'b0;
  logic [26:0] period_out, high_out;
  logic        valid, locked, stall;

  int n_cmp = 0;
  int n_bad = 0;
  int vc = 0;
  int per_log[256];
  int hi_log[256];
  int lk_log[256];
  int b;

  enemy_clk_monitor #(
    .W(27'd1000),
    .TOL(27'd16),
    .LOCK_N(4)
  ) dut (
    .clock_in(clk),
    .reset_n(reset_n),
    .y_in(y_in),
    .period_out(period_out),
    .high_out(high_out),
    .valid(valid),
    .locked(locked),
    .stall(stall)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid && vc < 256) begin
      per_log[vc] = int'(period_out);
      hi_log[vc]  = int'(high_out);
      lk_log[vc]  = int'(locked);
      vc++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wave(input int p, input int h);
    y_in = 1'b1;
    repeat (h) @(negedge clk);
    y_in = 1'b0;
    repeat (p - h) @(negedge clk);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_per"}, int'(period_out), 0);
    check({tag, "_hi"}, int'(high_out), 0);
    check({tag, "_val"}, int'(valid), 0);
    check({tag, "_lk"}, int'(locked), 0);
    check({tag, "_st"}, int'(stall), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // steady 1000/500 wave, lock on 5th rise
    b = vc;
    repeat (6) wave(1000, 500);
    check("n_valid1", vc - b, 5);
    check("per1", per_log[b], 1000);
    check("hi1", hi_log[b], 500);
    check("per5", per_log[b+3], 1000);
    check("lk_r4", lk_log[b+2], 0);
    check("lk_r5", lk_log[b+3], 1);

    // one period just outside, then four at the upper bound
    b = vc;
    wave(1017, 500);
    repeat (4) wave(1016, 500);
    wave(1000, 500);
    check("lk_pre", lk_log[b], 1);
    check("per_1017", per_log[b+1], 1017);
    check("lk_1017", lk_log[b+1], 0);
    check("lk_3x1016", lk_log[b+4], 0);
    check("per_1016", per_log[b+5], 1016);
    check("lk_4x1016", lk_log[b+5], 1);

    // hold low after a rise until stall
    y_in = 1'b1;
    repeat (500) @(negedge clk);
    y_in = 1'b0;
    repeat (1500) @(negedge clk);
    check("no_stall_2000", int'(stall), 0);
    check("lk_2000", int'(locked), 1);
    repeat (10) @(negedge clk);
    check("stall_2010", int'(stall), 1);
    check("lk_stall", int'(locked), 0);
    b = vc;
    wave(1000, 500);
    check("stall_clr", int'(stall), 0);
    check("stall_noval", vc - b, 0);

    // relock, then reset mid-period during low phase
    repeat (4) wave(1000, 500);
    check("relock", int'(locked), 1);
    y_in = 1'b1;
    repeat (500) @(negedge clk);
    y_in = 1'b0;
    repeat (200) @(negedge clk);
    pulse_reset();
    check_zero("midrst");
    repeat (300) @(negedge clk);
    b = vc;
    repeat (4) wave(1000, 500);
    check("lk_after4", int'(locked), 0);
    wave(1000, 500);
    check("lk_after5", int'(locked), 1);
    check("n_valid_rst", vc - b, 4);

    // 70% duty wave
    pulse_reset();
    @(negedge clk);
    b = vc;
    repeat (5) wave(1000, 700);
    check("duty_hi", hi_log[b+3], 700);
    check("duty_per", per_log[b+3], 1000);
`ifdef ENEMY_CLK_DUTY_CHECK_EN
    check("duty_lk", lk_log[b+3], 0);
`else
    check("duty_lk", lk_log[b+3], 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
